// File: rtl/exu_brstat_ctl_pkg.sv
// rtl/exu_brstat_ctl_pkg.sv - shared branch-statistics event indices and sizes (package veer_types)
package veer_types;
  typedef enum logic [2:0] {
    BRSTAT_PRED      = 3'd0,
    BRSTAT_CORRECT   = 3'd1,
    BRSTAT_MISPRED   = 3'd2,
    BRSTAT_COND_MISP = 3'd3,
    BRSTAT_PRED_T    = 3'd4,
    BRSTAT_PRED_NT   = 3'd5,
    BRSTAT_MISP_T    = 3'd6
  } brstat_evt_e;

  localparam int BRSTAT_NUM_EVT = 7;
  // Wide enough for a per-cycle step of up to two pipes.
  localparam int BRSTAT_STEP_W  = 2;
endpackage

// File: rtl/exu_brstat_cnt.sv
// rtl/exu_brstat_cnt.sv - one event counter: wrapping or saturating, sticky overflow, synchronous clear
module exu_brstat_cnt
  import veer_types::*;
#(
  parameter int CNT_W = 32,
  parameter int SAT   = 0
) (
  input  logic                     clk,
  input  logic                     rst_l,
  input  logic [BRSTAT_STEP_W-1:0] step,
  input  logic                     clr,
  output logic [CNT_W-1:0]         value,
  output logic                     ovf
);
  logic [CNT_W:0]   sum;
  logic [CNT_W-1:0] value_d;
  logic             ovf_d;

  always_comb begin
    sum = {1'b0, value} + {{(CNT_W + 1 - BRSTAT_STEP_W){1'b0}}, step};
    if (clr) begin
      value_d = '0;
      ovf_d   = 1'b0;
    end else begin
      // The carry out of the adder is exactly "this step crossed all-ones".
      ovf_d   = ovf | sum[CNT_W];
      value_d = ((SAT != 0) && sum[CNT_W]) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    end
  end

  rvdff #(.WIDTH(CNT_W)) u_value (.din(value_d), .clk(clk), .rst_l(rst_l), .dout(value));
  rvdff #(.WIDTH(1))     u_ovf   (.din(ovf_d),   .clk(clk), .rst_l(rst_l), .dout(ovf));
endmodule

// File: rtl/rvdff.sv
// rtl/rvdff.sv - plain register cell with asynchronous active-low reset to zero
module rvdff #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] din,
  input  logic             clk,
  input  logic             rst_l,
  output logic [WIDTH-1:0] dout
);
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) dout <= '0;
    else        dout <= din;
  end
endmodule

// File: rtl/exu_brstat_ctl.sv
// rtl/exu_brstat_ctl.sv - branch statistics counters with pipelined read port; RV_BRSTAT_SNAPSHOT_EN adds a shadow bank
module exu_brstat_ctl
  import veer_types::*;
#(
  parameter int NUM_PIPES = 2,
  parameter int CNT_W     = 32,
  parameter int SAT       = 0
) (
  input  logic                      clk,
  input  logic                      rst_l,
`ifdef RV_BRSTAT_SNAPSHOT_EN
  input  logic                      snap_req,
`endif
  input  logic [NUM_PIPES-1:0]      valid,
  input  logic [NUM_PIPES-1:0]      predict_t,
  input  logic [NUM_PIPES-1:0]      predict_nt,
  input  logic [NUM_PIPES-1:0]      actual_taken,
  input  logic [NUM_PIPES-1:0]      cond_mispredict,
  input  logic [NUM_PIPES-1:0]      flush_upper,
  input  logic                      flush,
  input  logic                      freeze,
  input  logic                      rd_req,
  input  logic [2:0]                rd_idx,
  output logic                      rd_ack,
  output logic [CNT_W-1:0]          rd_data,
  output logic                      rd_err,
  input  logic                      clr_req,
  output logic [BRSTAT_NUM_EVT-1:0] ovf
);
  logic [NUM_PIPES-1:0]     gate;
  logic [NUM_PIPES-1:0]     q;
  logic [NUM_PIPES-1:0]     hit  [BRSTAT_NUM_EVT];
  logic [BRSTAT_STEP_W-1:0] step [BRSTAT_NUM_EVT];
  logic [CNT_W-1:0]         live [BRSTAT_NUM_EVT];
  logic [CNT_W-1:0]         src  [BRSTAT_NUM_EVT];
  logic [CNT_W-1:0]         rd_sel;
  logic [CNT_W-1:0]         rd_data_d;
  logic                     rd_err_d;

  // Freeze and flush suppress every event, so a frozen cycle yields a zero step.
  assign gate = valid & {NUM_PIPES{~(flush | freeze)}};
  assign q    = gate & (predict_t | predict_nt);

  always_comb begin
    hit[int'(BRSTAT_PRED)]      = q;
    hit[int'(BRSTAT_CORRECT)]   = q & ~flush_upper;
    hit[int'(BRSTAT_MISPRED)]   = q & flush_upper;
    hit[int'(BRSTAT_COND_MISP)] = q & cond_mispredict;
    hit[int'(BRSTAT_PRED_T)]    = gate & predict_t;
    hit[int'(BRSTAT_PRED_NT)]   = gate & predict_nt;
    hit[int'(BRSTAT_MISP_T)]    = gate & predict_t & ~actual_taken;
  end

  always_comb begin
    for (int e = 0; e < BRSTAT_NUM_EVT; e++) begin
      step[e] = '0;
      for (int p = 0; p < NUM_PIPES; p++) begin
        step[e] = step[e] + {1'b0, hit[e][p]};
      end
    end
  end

  for (genvar e = 0; e < BRSTAT_NUM_EVT; e++) begin : g_evt
    exu_brstat_cnt #(.CNT_W(CNT_W), .SAT(SAT)) u_cnt (
      .clk   (clk),
      .rst_l (rst_l),
      .step  (step[e]),
      .clr   (clr_req),
      .value (live[e]),
      .ovf   (ovf[e])
    );
`ifdef RV_BRSTAT_SNAPSHOT_EN
    // Shadow captures the pre-update (and pre-clear) live value; clr leaves it alone.
    rvdff #(.WIDTH(CNT_W)) u_shadow (
      .din   (snap_req ? live[e] : src[e]),
      .clk   (clk),
      .rst_l (rst_l),
      .dout  (src[e])
    );
`else
    assign src[e] = live[e];
`endif
  end

  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < BRSTAT_NUM_EVT; i++) begin
      if (rd_idx == 3'(i)) rd_sel = src[i];
    end
  end

  // Read data is the value held before this edge's update, so it is latched from src directly.
  assign rd_err_d  = rd_req & (rd_idx == 3'(BRSTAT_NUM_EVT));
  assign rd_data_d = (rd_req & ~rd_err_d) ? rd_sel : '0;

  rvdff #(.WIDTH(1))     u_rd_ack  (.din(rd_req),    .clk(clk), .rst_l(rst_l), .dout(rd_ack));
  rvdff #(.WIDTH(1))     u_rd_err  (.din(rd_err_d),  .clk(clk), .rst_l(rst_l), .dout(rd_err));
  rvdff #(.WIDTH(CNT_W)) u_rd_data (.din(rd_data_d), .clk(clk), .rst_l(rst_l), .dout(rd_data));
endmodule

// File: tb/tb_exu_brstat_ctl.sv
// tb/tb_exu_brstat_ctl.sv - scoreboard bench: a wrapping and a saturating 16-bit instance on shared stimulus
module tb_exu_brstat_ctl;
  logic        clk = 1'b0;
  logic        rst_l;
  logic [1:0]  valid, predict_t, predict_nt, actual_taken, cond_mispredict, flush_upper;
  logic        flush, freeze, rd_req, clr_req;
  logic [2:0]  rd_idx;
  logic        rd_ack, rd_err, rd_ack_s, rd_err_s;
  logic [15:0] rd_data, rd_data_s;
  logic [6:0]  ovf, ovf_s;
`ifdef RV_BRSTAT_SNAPSHOT_EN
  logic        snap_req;
  localparam bit SNAP = 1'b1;
`else
  localparam bit SNAP = 1'b0;
`endif

  always #5 clk = ~clk;

  exu_brstat_ctl #(.NUM_PIPES(2), .CNT_W(16), .SAT(0)) dut (
    .clk(clk), .rst_l(rst_l),
`ifdef RV_BRSTAT_SNAPSHOT_EN
    .snap_req(snap_req),
`endif
    .valid(valid), .predict_t(predict_t), .predict_nt(predict_nt),
    .actual_taken(actual_taken), .cond_mispredict(cond_mispredict), .flush_upper(flush_upper),
    .flush(flush), .freeze(freeze), .rd_req(rd_req), .rd_idx(rd_idx),
    .rd_ack(rd_ack), .rd_data(rd_data), .rd_err(rd_err), .clr_req(clr_req), .ovf(ovf)
  );

  exu_brstat_ctl #(.NUM_PIPES(2), .CNT_W(16), .SAT(1)) dut_sat (
    .clk(clk), .rst_l(rst_l),
`ifdef RV_BRSTAT_SNAPSHOT_EN
    .snap_req(snap_req),
`endif
    .valid(valid), .predict_t(predict_t), .predict_nt(predict_nt),
    .actual_taken(actual_taken), .cond_mispredict(cond_mispredict), .flush_upper(flush_upper),
    .flush(flush), .freeze(freeze), .rd_req(rd_req), .rd_idx(rd_idx),
    .rd_ack(rd_ack_s), .rd_data(rd_data_s), .rd_err(rd_err_s), .clr_req(clr_req), .ovf(ovf_s)
  );

  typedef struct packed {
    logic [1:0] v, pt, pnt, at, cm, fu;
    logic       fl, fz, rr;
    logic [2:0] ri;
    logic       cl, sn;
  } stim_t;

  typedef struct {
    logic [15:0] d0, d1;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int unsigned m [2][7];
  int unsigned sh[2][7];
  logic [6:0]  mo[2];
  int          n_vec = 0;
  int          n_mis = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_upd(input stim_t s);
    int          st;
    logic        g, qq, h;
    int unsigned sum;
    if (s.sn) begin
      for (int d = 0; d < 2; d++)
        for (int e = 0; e < 7; e++) sh[d][e] = m[d][e];
    end
    for (int e = 0; e < 7; e++) begin
      st = 0;
      for (int p = 0; p < 2; p++) begin
        g  = s.v[p] & ~s.fl & ~s.fz;
        qq = g & (s.pt[p] | s.pnt[p]);
        case (e)
          0:       h = qq;
          1:       h = qq & ~s.fu[p];
          2:       h = qq & s.fu[p];
          3:       h = qq & s.cm[p];
          4:       h = g & s.pt[p];
          5:       h = g & s.pnt[p];
          default: h = g & s.pt[p] & ~s.at[p];
        endcase
        st += int'(h);
      end
      for (int d = 0; d < 2; d++) begin
        if (s.cl) begin
          m[d][e]  = 0;
          mo[d][e] = 1'b0;
        end else begin
          sum = m[d][e] + st;
          if (sum > 65535) begin
            mo[d][e] = 1'b1;
            m[d][e]  = (d == 0) ? sum - 65536 : 65535;
          end else begin
            m[d][e] = sum;
          end
        end
      end
    end
  endtask

  task automatic cyc(input stim_t s);
    exp_t x;
    valid = s.v; predict_t = s.pt; predict_nt = s.pnt; actual_taken = s.at;
    cond_mispredict = s.cm; flush_upper = s.fu; flush = s.fl; freeze = s.fz;
    rd_req = s.rr; rd_idx = s.ri; clr_req = s.cl;
`ifdef RV_BRSTAT_SNAPSHOT_EN
    snap_req = s.sn;
`endif
    if (s.rr) begin
      if (s.ri == 3'd7) begin
        x.d0 = '0; x.d1 = '0; x.err = 1'b1;
      end else begin
        x.d0  = 16'(SNAP ? sh[0][s.ri] : m[0][s.ri]);
        x.d1  = 16'(SNAP ? sh[1][s.ri] : m[1][s.ri]);
        x.err = 1'b0;
      end
      sb.push_back(x);
    end
    model_upd(s);
    @(posedge clk);
    #1;
    chk("rd_ack", rd_ack, s.rr);
    chk("rd_ack_sat", rd_ack_s, s.rr);
    if (rd_ack) begin
      if (sb.size() == 0) begin
        chk("sb_depth", 0, 1);
      end else begin
        x = sb.pop_front();
        chk($sformatf("rd_data[%0d]", s.ri), rd_data, x.d0);
        chk($sformatf("rd_data_sat[%0d]", s.ri), rd_data_s, x.d1);
        chk("rd_err", rd_err, x.err);
        chk("rd_err_sat", rd_err_s, x.err);
      end
    end
    @(negedge clk);
  endtask

  function automatic stim_t hit(input logic [1:0] v);
    stim_t s;
    s = '0; s.v = v; s.pt = v; s.at = v;
    return s;
  endfunction

  function automatic stim_t rd(input logic [2:0] idx);
    stim_t s;
    s = '0; s.rr = 1'b1; s.ri = idx;
    return s;
  endfunction

  task automatic chk_ovf(input string tag);
    chk({tag, "_ovf"}, ovf, mo[0]);
    chk({tag, "_ovf_sat"}, ovf_s, mo[1]);
  endtask

  initial begin
    stim_t s;
    for (int d = 0; d < 2; d++) begin
      mo[d] = '0;
      for (int e = 0; e < 7; e++) begin m[d][e] = 0; sh[d][e] = 0; end
    end
    rst_l = 1'b0;
    cyc_init: begin
      valid = '0; predict_t = '0; predict_nt = '0; actual_taken = '0;
      cond_mispredict = '0; flush_upper = '0; flush = 1'b0; freeze = 1'b0;
      rd_idx = '0; clr_req = 1'b0; rd_req = 1'b1;
`ifdef RV_BRSTAT_SNAPSHOT_EN
      snap_req = 1'b0;
`endif
    end
    repeat (2) @(negedge clk);
    chk("reset_rd_ack", rd_ack, 1'b0);
    chk("reset_rd_data", rd_data, 16'h0);
    chk("reset_rd_err", rd_err, 1'b0);
    chk_ovf("reset");
    rst_l = 1'b1; rd_req = 1'b0;
    @(posedge clk); #1;
    chk("post_reset_no_ack", rd_ack, 1'b0);
    @(negedge clk);

    // Both pipes predict taken and resolve taken for three cycles.
    repeat (3) cyc(hit(2'b11));
    cyc(rd(3'd0)); cyc(rd(3'd1)); cyc(rd(3'd4)); cyc(rd(3'd6));

    // Frozen or flushed events leave everything alone; reads and idx 7 still answer.
    for (int i = 0; i < 8; i++) begin
      s = hit(2'b11); s.pnt = 2'b01; s.fu = 2'b10; s.cm = 2'b11; s.at = 2'b00;
      if (i < 4) s.fz = 1'b1; else s.fl = 1'b1;
      cyc(s);
    end
    for (int i = 0; i < 8; i++) cyc(rd(3'(i)));

    // Random traffic with back-to-back reads.
    for (int i = 0; i < 60; i++) begin
      s = '0;
      s.v = 2'($urandom); s.pt = 2'($urandom); s.pnt = 2'($urandom); s.at = 2'($urandom);
      s.cm = 2'($urandom); s.fu = 2'($urandom);
      s.fl = ($urandom_range(0, 7) == 0); s.fz = ($urandom_range(0, 7) == 0);
      s.rr = ($urandom_range(0, 2) != 0); s.ri = 3'($urandom_range(0, 7));
      cyc(s);
    end
    for (int i = 0; i < 7; i++) cyc(rd(3'(i)));

    // Clear beats same-edge hits; a coincident read returns the pre-clear value.
    s = '0; s.cl = 1'b1; cyc(s);
    cyc(hit(2'b11)); cyc(hit(2'b11)); cyc(hit(2'b01));
    s = hit(2'b11); s.cl = 1'b1; s.rr = 1'b1; s.ri = 3'd0; cyc(s);
    cyc(rd(3'd0)); cyc(rd(3'd1));
    chk_ovf("clr");

    // Drive PRED to 0xFFFE, then cross all-ones one hit at a time.
    s = '0; s.cl = 1'b1; cyc(s);
    for (int i = 0; i < 32767; i++) cyc(hit(2'b11));
    cyc(rd(3'd0));
    cyc(hit(2'b01));
    cyc(rd(3'd0));
    chk_ovf("at_max");
    cyc(hit(2'b10));
    cyc(rd(3'd0));
    chk_ovf("wrap");
    cyc(hit(2'b01));
    cyc(rd(3'd0)); cyc(rd(3'd4));
    chk_ovf("sticky");
    s = '0; s.cl = 1'b1; cyc(s);
    chk_ovf("ovf_clr");
    cyc(rd(3'd0));

`ifdef RV_BRSTAT_SNAPSHOT_EN
    // Shadow keeps 9 while live advances to 13; a second snapshot exposes the live value.
    repeat (4) cyc(hit(2'b11));
    cyc(hit(2'b01));
    s = '0; s.sn = 1'b1; cyc(s);
    repeat (2) cyc(hit(2'b11));
    cyc(rd(3'd0));
    s = hit(2'b11); s.cl = 1'b1; s.sn = 1'b1; cyc(s);
    cyc(rd(3'd0));
`endif

    repeat (2) cyc('0);
    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule

// File: doc/exu_brstat_ctl.md
EXU_BRSTAT_CTL -- requirements
Module: exu_brstat_ctl

Interface
REQ-001 SHALL have parameter NUM_PIPES, default 2, number of ALU pipes reporting branch events (legal 1..2).
REQ-002 SHALL have parameter CNT_W, default 32, counter width in bits (legal 16..64).
REQ-003 SHALL have parameter SAT, default 0; 1 = saturating counters, 0 = wrapping counters.
REQ-004 SHALL have port clk input 1, the single clock.
REQ-005 SHALL have port rst_l input 1; reset is asynchronous and active-low.
REQ-006 SHALL have ports valid, predict_t, predict_nt, actual_taken, cond_mispredict, flush_upper, each input NUM_PIPES, per-pipe resolved-branch status.
REQ-007 SHALL have ports flush and freeze, each input 1, global pipeline flush and freeze.
REQ-008 SHALL have ports rd_req input 1, rd_idx input 3, rd_ack output 1, rd_data output CNT_W, rd_err output 1, forming the counter read port.
REQ-009 SHALL have port clr_req input 1, a synchronous clear of all counters and overflow flags.
REQ-010 SHALL have port ovf output 7, sticky per-counter overflow flags.
REQ-011 SHALL have port snap_req input 1, present only with RV_BRSTAT_SNAPSHOT_EN.

Function
REQ-012 SHALL define per-pipe qualifier q[p] = valid[p] & (predict_t[p] | predict_nt[p]) & ~flush & ~freeze.
REQ-013 SHALL increment these 7 events per pipe:
- idx0 PRED: q
- idx1 CORRECT: q & ~flush_upper
- idx2 MISPRED: q & flush_upper
- idx3 COND_MISP: q & cond_mispredict
- idx4 PRED_T: valid & predict_t & ~flush & ~freeze
- idx5 PRED_NT: valid & predict_nt & ~flush & ~freeze
- idx6 MISP_T: valid & predict_t & ~actual_taken & ~flush & ~freeze
REQ-014 SHALL add each counter's per-pipe hits in one cycle, giving a step of 0..NUM_PIPES, and update one cycle after the events.
REQ-015 With SAT=0, SHALL wrap modulo 2^CNT_W, so that max-1 plus 2 yields 0, and SHALL set the matching ovf bit when a wrap occurs.
REQ-016 With SAT=1, SHALL clamp at all-ones and set the matching ovf bit on any step that would exceed it.
REQ-017 SHALL keep ovf bits sticky until clr_req or reset.
REQ-018 SHALL sample rd_req and rd_idx at a clock edge and, on the next cycle, assert rd_ack for exactly 1 cycle with rd_data equal to the counter value held before that edge's update.
REQ-019 SHALL accept back-to-back rd_req every cycle (fully pipelined).
REQ-020 With rd_idx=7, SHALL return rd_data=0 and rd_err=1 alongside rd_ack; otherwise rd_err=0.
REQ-021 SHALL give clr_req priority over same-cycle increments: all counters and ovf become 0 and that cycle's events are dropped.
REQ-022 On rd_req coincident with clr_req, SHALL return the pre-clear value.
REQ-023 When freeze=1, SHALL leave all counters unchanged; rd and clr SHALL still operate.

Reset
REQ-024 SHALL, while rst_l=0, asynchronously force counters=0, ovf=0, rd_ack=0, rd_data=0, rd_err=0 (and snapshot bank=0).
REQ-025 SHALL drop any in-flight read on reset: no rd_ack follows deassertion.

Configuration
REQ-026 With RV_BRSTAT_SNAPSHOT_EN defined, SHALL copy all 7 live counters atomically into a shadow bank on snap_req, taking the pre-update values of that edge, and reads SHALL return shadow values.
REQ-027 With RV_BRSTAT_SNAPSHOT_EN defined, clr_req SHALL clear only live counters, and on snap_req coincident with clr_req the shadow SHALL capture the pre-clear values.
REQ-028 Without RV_BRSTAT_SNAPSHOT_EN, SHALL have no snap_req port and no shadow bank, and reads SHALL return live counters.

Structure
REQ-029 SHALL place the brstat_evt_e enum (indices 0..6) and BRSTAT_NUM_EVT=7 in veer_types.
REQ-030 SHALL implement one sub-module, exu_brstat_cnt (CNT_W, SAT parameters; step input, clr input, value and ovf outputs), instantiated 7 times.
REQ-031 SHALL build all flops from rvdff-family cells.

Verification
REQ-032 SHALL cover: NUM_PIPES=2, both pipes valid, predict_t=1, actual_taken=1, flush_upper=0 for 3 cycles -> PRED=6, CORRECT=6, PRED_T=6, MISP_T=0.
REQ-033 SHALL cover: SAT=0, CNT_W=16, PRED preset to 0xFFFF, one pipe hit -> PRED=0, ovf[0]=1; then clr_req -> ovf[0]=0.
REQ-034 SHALL cover: SAT=1, CNT_W=16, PRED=0xFFFE, two hits -> PRED=0xFFFF, ovf[0]=1; a further hit -> PRED stays 0xFFFF.
REQ-035 SHALL cover: events with freeze=1 or flush=1 for 4 cycles -> all counters unchanged; rd_req idx7 -> rd_ack next cycle, rd_data=0, rd_err=1.
REQ-036 SHALL cover: clr_req plus 2 hits plus rd_req idx0 on the same edge with PRED=5 -> rd_data=5, then PRED=0.
REQ-037 SHALL cover, with RV_BRSTAT_SNAPSHOT_EN: PRED=9, snap_req, then 4 hits -> read idx0 returns 9 while live PRED=13.
